// File: rtl/rda_sum_stage.sv
// rda_sum_stage: output stage of the 8-bit recursive doubling adder.
// Takes the carry-status vector fed into the prefix circuit (x_in) and the
// resolved vector it returns (y_in), pipelines them through a capture stage
// and a result stage, and presents sum/cout/ovf/zero with valid/ready flow.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    upstream handshake for x_in/y_in
//   x_in[17:0]            9 status pairs, pair i = bits [2i+1:2i]
//   y_in[17:0]            resolved carries for pairs 0..7, pair 8 passthrough
//   out_valid, out_ready  downstream handshake for the result
//   sum, cout, ovf, zero  result and flags
//   err                   sticky: some delivered operation had an unresolved pair
//   res_count             saturating count of delivered results
module rda_sum_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      x_in,
    input  logic [17:0]      y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             err,
    output logic [CNT_W-1:0] res_count
);
    logic       s1_valid, s1_g7, s1_bad;
    logic [7:0] s1_c, s1_p;
    logic [7:0] c_in, p_in;
    logic       bad_in, s2_adv, accept, hs;
    logic [7:0] nsum;
    logic       ncout;
    always_comb begin
        c_in   = '0;
        p_in   = '0;
        bad_in = 1'b0;
        for (int j = 0; j < 8; j++) begin
            c_in[j] = y_in[2*j+1];
            p_in[j] = x_in[2*j+3] ^ x_in[2*j+2];
            // a resolved pair is 00 or 11; anything else means the prefix circuit left it open
            bad_in  = bad_in | (y_in[2*j+1] ^ y_in[2*j]);
        end
    end
    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    assign accept   = in_valid & in_ready;
    assign hs       = out_valid & out_ready;
    assign nsum     = s1_p ^ s1_c;
    assign ncout    = s1_g7 | (s1_p[7] & s1_c[7]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_p     <= '0;
            s1_g7    <= 1'b0;
            s1_bad   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_c     <= c_in;
            s1_p     <= p_in;
            s1_g7    <= x_in[17] & x_in[16];
            s1_bad   <= bad_in;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            res_count <= '0;
        end else begin
            if (s2_adv) begin
                out_valid <= 1'b1;
                sum       <= nsum;
                cout      <= ncout;
                ovf       <= s1_c[7] ^ ncout;
                zero      <= ~|nsum;
                err       <= err | s1_bad;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (hs && !(&res_count))
                res_count <= res_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rda_sum_stage.sv
// tb_rda_sum_stage: randomized and directed check of rda_sum_stage against a queue-level adder model.
module tb_rda_sum_stage;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [17:0] x_in = '0, y_in = '0;
    logic        in_ready, out_valid, cout, ovf, zero, err;
    logic [7:0]  sum;
    logic [15:0] res_count;

    rda_sum_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .err(err), .res_count(res_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] a, b; logic cin; int bad;} op_t;
    typedef struct {logic [7:0] sum; logic cout, ovf, zero, bad; int t;} res_t;

    op_t  stim[$];
    res_t pend[$];
    int   n_tests = 0, n_fail = 0, cyc = 0, hs_cnt = 0;
    int   iv_mode = 1, or_mode = 1;
    logic err_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic res_t model(input op_t o);
        res_t r;
        int   s;
        s      = int'(o.a) + int'(o.b) + int'(o.cin);
        r.sum  = s[7:0];
        r.cout = s[8];
        r.ovf  = (o.a[7] == o.b[7]) && (s[7] != o.a[7]);
        r.zero = (s[7:0] == 0);
        r.bad  = (o.bad >= 0);
        r.t    = 0;
        return r;
    endfunction

    function automatic op_t mk(input logic [7:0] a, input logic [7:0] b, input logic cin, input int bad);
        op_t o;
        o.a = a; o.b = b; o.cin = cin; o.bad = bad;
        return o;
    endfunction

    // Builds the prefix-circuit input and a correctly resolved output; a "bad" pair
    // keeps its carry bit but breaks the pair so the sum itself is unaffected.
    task automatic drive();
        op_t  o;
        int   tmp;
        logic c;
        if (stim.size() > 0 && (iv_mode == 1 || $urandom_range(1, 0) == 1)) begin
            o = stim[0];
            in_valid = 1'b1;
            x_in[1:0] = {o.cin, o.cin};
            for (int j = 0; j < 8; j++) begin
                x_in[2*j+2 +: 2] = {o.a[j], o.b[j]};
                tmp = (int'(o.a) & ((1 << j) - 1)) + (int'(o.b) & ((1 << j) - 1)) + int'(o.cin);
                c = tmp[j];
                y_in[2*j +: 2] = (j == o.bad) ? {c, ~c} : {c, c};
            end
            y_in[17:16] = x_in[17:16];
        end else begin
            in_valid = 1'b0;
            x_in = 18'($urandom);
            y_in = 18'($urandom);
        end
        out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom_range(1, 0));
    endtask

    task automatic step();
        logic ov_exp, ir_exp, hs, acc;
        res_t r;
        @(negedge clk);
        ov_exp = pend.size() >= 2 || (pend.size() == 1 && pend[0].t != cyc);
        ir_exp = pend.size() < 2 || out_ready;
        chk("out_valid", out_valid, ov_exp);
        chk("in_ready", in_ready, ir_exp);
        if (ov_exp) begin
            chk("sum", sum, pend[0].sum);
            chk("cout", cout, pend[0].cout);
            chk("ovf", ovf, pend[0].ovf);
            chk("zero", zero, pend[0].zero);
        end
        chk("err", err, err_seen | (ov_exp && pend[0].bad));
        chk("res_count", res_count, hs_cnt);
        hs  = ov_exp && out_ready;
        acc = in_valid && ir_exp;
        @(posedge clk);
        cyc++;
        if (hs) begin
            err_seen = err_seen | pend[0].bad;
            void'(pend.pop_front());
            hs_cnt++;
        end
        if (acc) begin
            r = model(stim.pop_front());
            r.t = cyc;
            pend.push_back(r);
        end
        #1 drive();
    endtask

    task automatic run(input int budget);
        drive();
        for (int i = 0; i < budget && (stim.size() > 0 || pend.size() > 0); i++) step();
        chk("drain", stim.size() + pend.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_flags", {sum, cout, ovf, zero, err}, 0);
        chk("rst_res_count", res_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // directed arithmetic cases
        iv_mode = 1; or_mode = 1;
        stim.push_back(mk(8'h0F, 8'h01, 1'b0, -1));
        stim.push_back(mk(8'hFF, 8'h00, 1'b1, -1));
        stim.push_back(mk(8'h7F, 8'h01, 1'b0, -1));
        stim.push_back(mk(8'h80, 8'h80, 1'b0, -1));
        run(50);
        // four back-to-back
        for (int i = 0; i < 4; i++) stim.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom), -1));
        run(50);
        // backpressure: hold out_ready low, then release
        for (int i = 0; i < 4; i++) stim.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom), -1));
        or_mode = 2;
        drive();
        repeat (6) step();
        or_mode = 1;
        run(50);
        // unresolved pair 3 (carry into bit 3 is 0, so pair becomes 01), then clean ops
        stim.push_back(mk(8'h10, 8'h01, 1'b0, 3));
        stim.push_back(mk(8'h22, 8'h33, 1'b0, -1));
        stim.push_back(mk(8'h44, 8'h05, 1'b1, -1));
        run(50);
        chk("err_sticky", err, 1);
        // random traffic with random handshakes
        iv_mode = 0; or_mode = 0;
        for (int i = 0; i < 200; i++)
            stim.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom),
                              ($urandom_range(15, 0) == 0) ? int'($urandom_range(7, 0)) : -1));
        run(3000);
        // reset with both stages full and err set
        iv_mode = 1; or_mode = 2;
        stim.push_back(mk(8'h10, 8'h01, 1'b0, 3));
        stim.push_back(mk(8'h01, 8'h02, 1'b0, -1));
        stim.push_back(mk(8'h03, 8'h04, 1'b0, -1));
        drive();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_res_count", res_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        stim.delete(); pend.delete();
        err_seen = 1'b0; hs_cnt = 0; in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        or_mode = 1;
        stim.push_back(mk(8'h0F, 8'h01, 1'b0, -1));
        stim.push_back(mk(8'hFF, 8'hFF, 1'b1, -1));
        run(50);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
